reg_block_serializer: RTL and testbench

REG_BLOCK_SERIALIZER -- requirements
Module: reg_block_serializer

---
 rtl/reg_block_serializer_pkg.sv | 11 +
 rtl/reg_block_serializer_register.sv | 22 ++
 rtl/reg_block_serializer.sv | 102 ++++++++++
 tb/tb_reg_block_serializer.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/reg_block_serializer_pkg.sv
// Shared types for the 4-word serializer: FSM states and frame geometry.
package reg_block_serializer_pkg;
    localparam int WORDS = 4;
    localparam int IDX_W = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/reg_block_serializer_register.sv
// N-bit enable register, async active-high clear; loads i_d on the edge where i_en is high.
module register #(
    parameter int N = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_en,
    input  logic [N-1:0] i_d,
    output logic [N-1:0] o_q
);
    logic [N-1:0] r_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= '0;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;
endmodule

// File: rtl/reg_block_serializer.sv
// Captures in0..in3 on start, then offers them in order over valid/ready; words follow start by one cycle,
// a stalled word holds indefinitely while out_ready is low, and a one-cycle done closes the frame.
module reg_block_serializer
    import reg_block_serializer_pkg::*;
#(
    parameter int N = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] in0,
    input  logic [N-1:0] in1,
    input  logic [N-1:0] in2,
    input  logic [N-1:0] in3,
    output logic         busy,
    output logic [N-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [1:0]   out_idx,
    output logic         out_last,
    output logic         done
);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    state_t           r_state;
    state_t           w_next_state;
    logic [IDX_W-1:0] r_idx;
    logic             w_load;
    logic             w_xfer;
    logic [N-1:0]     w_in  [WORDS];
    logic [N-1:0]     w_buf [WORDS];

    assign w_load = (r_state == IDLE) && start;
    assign w_xfer = (r_state == SEND) && out_ready;

    assign w_in[0] = in0;
    assign w_in[1] = in1;
    assign w_in[2] = in2;
    assign w_in[3] = in3;

    for (genvar g = 0; g < WORDS; g++) begin : g_word
        register #(.N(N)) u_register (
            .clk  (clk),
            .rst  (rst),
            .i_en (w_load),
            .i_d  (w_in[g]),
            .o_q  (w_buf[g])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (start) w_next_state = SEND;
            SEND:    if (w_xfer && (r_idx == LAST_IDX)) w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // idx parks on the last word once it is accepted; the next capture re-zeroes it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx <= '0;
        end else if (w_load) begin
            r_idx <= '0;
        end else if (w_xfer && (r_idx != LAST_IDX)) begin
            r_idx <= r_idx + 1'b1;
        end
    end

    always_comb begin
        out_valid = 1'b0;
        out_data  = '0;
        out_idx   = '0;
        out_last  = 1'b0;
        done      = 1'b0;
        busy      = 1'b0;
        case (r_state)
            SEND: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_data  = w_buf[r_idx];
                out_idx   = r_idx;
                out_last  = (r_idx == LAST_IDX);
            end
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_reg_block_serializer.sv
// Self-checking bench for reg_block_serializer: directed frame table, corner sequences, random frames.
module tb_reg_block_serializer;
    localparam int N = 5;

    logic         clk;
    logic         rst;
    logic         start;
    logic [N-1:0] in0, in1, in2, in3;
    logic         busy;
    logic [N-1:0] out_data;
    logic         out_valid;
    logic         out_ready;
    logic [1:0]   out_idx;
    logic         out_last;
    logic         done;

    int checks   = 0;
    int failures = 0;

    reg_block_serializer #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in0       (in0),
        .in1       (in1),
        .in2       (in2),
        .in3       (in3),
        .busy      (busy),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .done      (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [3:0][N-1:0] w;
        logic [31:0]       rpat;
        bit                scr;
        int                exp_done;
        logic [3:0][N-1:0] exp_w;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_valid"}, out_valid, 0);
        chk({tag, "_data"},  out_data,  0);
        chk({tag, "_idx"},   out_idx,   0);
        chk({tag, "_last"},  out_last,  0);
        chk({tag, "_done"},  done,      0);
        chk({tag, "_busy"},  busy,      0);
    endtask

    function automatic logic [3:0][N-1:0] mk(input int a, input int b, input int c, input int d);
        logic [3:0][N-1:0] r;
        r[0] = N'(a);
        r[1] = N'(b);
        r[2] = N'(c);
        r[3] = N'(d);
        return r;
    endfunction

    // Reference: word k is on the bus until the k-th ready cycle of the frame, done follows the 4th,
    // and the block is idle the cycle after done. rpat bit t is out_ready during frame cycle t.
    task automatic run_frame(input logic [3:0][N-1:0] w, input logic [3:0][N-1:0] ew,
                             input logic [31:0] rpat, input bit scr, input bit hold,
                             input int exp_done);
        int pos;
        int t;
        bit fin;
        {in3, in2, in1, in0} = w;
        start     = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        chk("pre_busy", busy, 0);
        @(posedge clk); #1;
        if (!hold) start = 1'b0;
        if (scr) {in3, in2, in1, in0} = '1;
        pos = 0;
        t   = 1;
        fin = 1'b0;
        while (!fin && t < 40) begin
            out_ready = (t < 32) ? rpat[t] : 1'b1;
            @(negedge clk);
            if (pos < 4) begin
                chk("word_valid", out_valid, 1);
                chk("word_data",  out_data,  ew[pos]);
                chk("word_idx",   out_idx,   pos);
                chk("word_last",  out_last,  (pos == 3) ? 1 : 0);
                chk("word_done",  done,      0);
                chk("word_busy",  busy,      1);
                if (out_ready) pos++;
            end else if (pos == 4) begin
                chk("done_pulse", done,      1);
                chk("done_valid", out_valid, 0);
                chk("done_busy",  busy,      1);
                if (exp_done >= 0) chk("done_cycle", t, exp_done);
                pos = 5;
            end else begin
                chk("end_busy",  busy,      0);
                chk("end_done",  done,      0);
                chk("end_valid", out_valid, 0);
                fin = 1'b1;
            end
            @(posedge clk); #1;
            t++;
        end
        if (!fin) begin
            checks++;
            failures++;
            $display("FAIL frame_timeout: got pos %0d expected frame end within 40 cycles", pos);
        end
        out_ready = 1'b0;
    endtask

    vec_t vecs[5];

    initial begin
        logic [3:0][N-1:0] rw;
        logic [31:0]       rp;

        vecs[0] = '{w: mk(1, 2, 3, 4),   rpat: 32'hFFFF_FFFF, scr: 1'b0, exp_done: 5, exp_w: mk(1, 2, 3, 4)};
        vecs[1] = '{w: mk(1, 2, 3, 4),   rpat: 32'hFFFF_FFE3, scr: 1'b0, exp_done: 8, exp_w: mk(1, 2, 3, 4)};
        vecs[2] = '{w: mk(1, 2, 3, 4),   rpat: 32'hFFFF_FFFF, scr: 1'b1, exp_done: 5, exp_w: mk(1, 2, 3, 4)};
        vecs[3] = '{w: mk(31, 0, 31, 0), rpat: 32'hFFFF_FFFF, scr: 1'b0, exp_done: 5, exp_w: mk(31, 0, 31, 0)};
        vecs[4] = '{w: mk(7, 24, 9, 22), rpat: 32'hFFFF_FFCF, scr: 1'b0, exp_done: 7, exp_w: mk(7, 24, 9, 22)};

        rst = 1'b1;
        start = 1'b0;
        out_ready = 1'b0;
        {in3, in2, in1, in0} = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_quiet("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk_quiet("post_reset");
        @(posedge clk); #1;

        for (int i = 0; i < 5; i++) begin
            run_frame(vecs[i].w, vecs[i].exp_w, vecs[i].rpat, vecs[i].scr, 1'b0, vecs[i].exp_done);
        end

        // start held high through the whole frame while inputs change: one frame, then recapture
        run_frame(mk(3, 1, 4, 1), mk(3, 1, 4, 1), 32'hFFFF_FFFF, 1'b1, 1'b1, 5);
        @(negedge clk);
        chk("restart_valid", out_valid, 1);
        chk("restart_idx",   out_idx,   0);
        chk("restart_data",  out_data,  31);
        @(posedge clk); #1;
        start = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // asynchronous reset at idx=2, with start held during reset
        {in3, in2, in1, in0} = {5'd8, 5'd7, 5'd6, 5'd5};
        start = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("pre_rst_idx",  out_idx,  2);
        chk("pre_rst_data", out_data, 7);
        #2;
        rst = 1'b1;
        start = 1'b1;
        #1;
        chk_quiet("async_rst");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_quiet("in_rst");
        end
        @(posedge clk); #1;
        rst = 1'b0;
        run_frame(mk(9, 10, 11, 12), mk(9, 10, 11, 12), 32'hFFFF_FFFF, 1'b0, 1'b0, 5);

        for (int f = 0; f < 30; f++) begin
            for (int k = 0; k < 4; k++) rw[k] = N'($urandom);
            rp = $urandom;
            run_frame(rw, rw, rp, ($urandom_range(0, 1) == 1), 1'b0, -1);
            repeat ($urandom_range(0, 3)) begin
                {in3, in2, in1, in0} = $urandom;
                out_ready = 1'(($urandom));
                @(negedge clk);
                chk_quiet("gap");
                @(posedge clk); #1;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
